// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (operand1 - operand2 - borrow_in), one full-subtractor cell, LSB first.
// Optional add mode selected at build time with SERIAL_SUB_ADD_MODE_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             borrow_in,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  function automatic logic diff_bit(input logic a, input logic b, input logic bw);
    return a ^ b ^ bw;
  endfunction

  function automatic logic borrow_bit(input logic a, input logic b, input logic bw);
    return (~a & b) | (~a & bw) | (b & bw);
  endfunction

  // Add mode flags overflow when like-signed operands give an unlike-signed sum.
  function automatic logic ovf_flag(input logic m1, input logic m2, input logic rm,
                                    input logic add);
    if (add)
      return (m1 == m2) && (rm != m1);
    else
      return (m1 != m2) && (rm != m1);
  endfunction

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             bw;
  logic [CNT_W-1:0] count;
  logic             op1_msb;
  logic             op2_msb;
  logic             add_q;

  logic             b_eff;
  logic             d_bit;
  logic             bw_next;

  // In add mode the cell sees ~operand2 and an inverted borrow, so the
  // subtractor computes op1 + op2 + cin with borrow = ~carry.
  always_comb begin
    b_eff   = b_sh[0] ^ add_q;
    d_bit   = diff_bit(a_sh[0], b_eff, bw);
    bw_next = borrow_bit(a_sh[0], b_eff, bw);
  end

`ifdef SERIAL_SUB_ADD_MODE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      add_q <= 1'b0;
    else if (state == IDLE && start)
      add_q <= mode;
  end
`else
  assign add_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      bw         <= 1'b0;
      count      <= '0;
      op1_msb    <= 1'b0;
      op2_msb    <= 1'b0;
      result     <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= operand1;
            b_sh    <= operand2;
`ifdef SERIAL_SUB_ADD_MODE_EN
            bw      <= borrow_in ^ mode;
`else
            bw      <= borrow_in;
`endif
            op1_msb <= operand1[WIDTH-1];
            op2_msb <= operand2[WIDTH-1];
            count   <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= {d_bit, res_sh[WIDTH-1:1]};
          bw     <= bw_next;
          count  <= count + CNT_W'(1);
          // Last bit: publish the finished word and flags on entry to DONE.
          if (count == LAST_BIT) begin
            result     <= {d_bit, res_sh[WIDTH-1:1]};
            borrow_out <= bw_next ^ add_q;
            overflow   <= ovf_flag(op1_msb, op2_msb, d_bit, add_q);
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results, a monitor checks them on done.
`timescale 1ns/1ps
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             borrow_in;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic             mode;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             borrow_out;
  logic             overflow;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .operand1(operand1), .operand2(operand2), .borrow_in(borrow_in),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .mode(mode),
`endif
    .busy(busy), .done(done), .result(result),
    .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             bo;
    logic             ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done cycle.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("borrow_out", 32'(borrow_out), 32'(e.bo));
        check("overflow", 32'(overflow), 32'(e.ov));
      end
      if (done_prev) check("done_one_cycle", 32'd1, 32'd0);
      if (busy) check("busy_during_done", 32'd1, 32'd0);
    end
    done_prev <= done;
  end

  // Issues one operation and checks latency and busy length.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                        input logic [WIDTH-1:0] er, input logic eb, input logic eo);
    int edges;
    int busy_cnt;
    exp_t e;
    @(negedge clk);
    operand1 = a; operand2 = b; borrow_in = bin; start = 1'b1;
    e.res = er; e.bo = eb; e.ov = eo;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    operand1 = ~a; operand2 = ~b; borrow_in = ~bin;
    edges = 0; busy_cnt = 0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1 edges++;
      if (done) break;
    end
    check("latency", 32'(edges), 32'(WIDTH));
    check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 0; i < 4 * WIDTH; i++) begin
      @(posedge clk);
      #1 edges++;
      if (done) return;
    end
    check("done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int   edges;
    int   busy_seen;
    exp_t e;
    rst = 1'b1; start = 1'b0; operand1 = '0; operand2 = '0; borrow_in = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    mode = 1'b0;
`endif
    // 1: reset state, no activity with start low.
    repeat (3) @(posedge clk);
    #1 check("rst_result", 32'(result), 32'h0);
    check("rst_flags", {30'd0, borrow_out, overflow}, 32'h0);
    check("rst_busy_done", {30'd0, busy, done}, 32'h0);
    @(negedge clk) rst = 1'b0;
    busy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done) busy_seen++;
    end
    check("idle_no_busy", 32'(busy_seen), 32'd0);

    // 2, 3: directed vectors.
    run_op(8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op(8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1);
    run_op(8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);
    run_op(8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b1);

    // 4: start held with new operands through SHIFT and DONE is ignored.
    @(negedge clk);
    operand1 = 8'h50; operand2 = 8'h20; borrow_in = 1'b0; start = 1'b1;
    e.res = 8'h30; e.bo = 1'b0; e.ov = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1 operand1 = 8'h11; operand2 = 8'h22; borrow_in = 1'b1;
    wait_done(edges);
    @(posedge clk);
    #1 start = 1'b0;
    busy_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done) busy_seen++;
    end
    check("ignored_start", 32'(busy_seen), 32'd0);
    run_op(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);

    // Back-to-back with start held: one operation every WIDTH+2 cycles.
    @(negedge clk);
    operand1 = 8'h20; operand2 = 8'h10; borrow_in = 1'b0; start = 1'b1;
    e.res = 8'h10; e.bo = 1'b0; e.ov = 1'b0;
    exp_q.push_back(e);
    exp_q.push_back(e);
    wait_done(edges);
    wait_done(edges);
    check("throughput", 32'(edges), 32'(WIDTH + 2));
    start = 1'b0;
    repeat (3) @(negedge clk);

    // 5: asynchronous reset mid-SHIFT.
    @(negedge clk);
    operand1 = 8'h10; operand2 = 8'h01; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", 32'(result), 32'h0);
    check("arst_flags", {30'd0, borrow_out, overflow}, 32'h0);
    @(negedge clk) rst = 1'b0;
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

`ifdef SERIAL_SUB_ADD_MODE_EN
    // 6: add mode.
    mode = 1'b1;
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    mode = 1'b0;
    run_op(8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
